// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and op classification helpers.
package md_pkg;

    localparam logic [2:0] MD_MULTU = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_DIVU  = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;
    localparam logic [2:0] MD_MADD  = 3'b110;
    localparam logic [2:0] MD_MSUB  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    function automatic logic is_mul_class(input logic [2:0] op);
        return (op == MD_MULTU) || (op == MD_MULT) ||
               (op == MD_MADD)  || (op == MD_MSUB);
    endfunction

    function automatic logic is_div_class(input logic [2:0] op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    // Ops whose operands are two's complement.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV) ||
               (op == MD_MADD) || (op == MD_MSUB);
    endfunction

endpackage

// File: rtl/md_unit_iter_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// start is a one-edge strobe honoured only while busy is low; there is no
// ready signal, the issuer stalls on busy. done pulses for one cycle when a
// multi-cycle op writes HI/LO.
interface md_unit_iter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic [2:0]       op;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    modport master (
        output a, b, start, op, flush,
        input  busy, done, hi, lo, dbg_state
    );

    modport slave (
        input  a, b, start, op, flush,
        output busy, done, hi, lo, dbg_state
    );
endinterface

// File: rtl/md_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the remainder and subtract the divisor if it fits.
module md_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dividend_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // One extra bit: the shifted remainder can reach 2*divisor-1.
    assign shifted       = {rem, dividend[WIDTH-1]};
    assign diff          = shifted - {1'b0, divisor};
    assign q_bit         = ~diff[WIDTH];
    assign rem_next      = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dividend_next = {dividend[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/md_unit_iter.sv
// Multi-cycle multiply/divide unit owning HI/LO. Multiplies wait a fixed
// latency before commit; divides run one restoring step per cycle plus a sign fix.
module md_unit_iter
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input logic           clk,
    input logic           reset,
    md_unit_iter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 16);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;

    logic               sgn;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_rem, step_dvd;
    logic               step_q;

    // Sign-extending to 2*WIDTH makes a single multiplier serve both signednesses.
    assign sgn   = is_signed_op(bus.op);
    assign a_ext = {{WIDTH{sgn & bus.a[WIDTH-1]}}, bus.a};
    assign b_ext = {{WIDTH{sgn & bus.b[WIDTH-1]}}, bus.b};
    assign prod  = a_ext * b_ext;
    assign acc   = {hi_q, lo_q};
    assign a_mag = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    md_div_step #(.WIDTH(WIDTH)) u_step (
        .rem           (rem_q),
        .dividend      (dvd_q),
        .divisor       (dvs_q),
        .rem_next      (step_rem),
        .dividend_next (step_dvd),
        .q_bit         (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == MD_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == MD_MTLO) begin
                        lo_d = bus.a;
                    end else if (is_mul_class(bus.op)) begin
                        if (bus.op == MD_MADD)      res_d = acc + prod;
                        else if (bus.op == MD_MSUB) res_d = acc - prod;
                        else                        res_d = prod;
                        cnt_d   = CNT_W'(MUL_CYCLES);
                        state_d = ST_MUL;
                    end else if (is_div_class(bus.op) && (bus.b != '0)) begin
                        rem_d     = '0;
                        dvd_d     = a_mag;
                        dvs_d     = b_mag;
                        quo_d     = '0;
                        neg_quo_d = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem_d = sgn & bus.a[WIDTH-1];
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res_q[2*WIDTH-1:WIDTH];
                    lo_d    = res_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A squash discards everything decided above, including an IDLE start.
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            res_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.dbg_state = state_q;
endmodule
